// File: rtl/planificador_cuenta_pkg.sv
// Shared definitions for the count sequencer: widths, default FIFO depth and FSM states.
package planificador_cuenta_pkg;

    localparam int unsigned ANCHO_VALOR  = 3;
    localparam int unsigned ANCHO_CUENTA = 4;
    localparam int unsigned PROF_DEF     = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLanza,
        StEsperaBaja,
        StEsperaFin,
        StEntrega
    } estado_t;

endpackage

// File: rtl/fifo_valores.sv
// Synchronous FIFO for the values awaiting a count; pointers carry one extra wrap bit.
module fifo_valores
    import planificador_cuenta_pkg::*;
#(
    parameter int unsigned PROF  = PROF_DEF,
    parameter int unsigned ANCHO = ANCHO_VALOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [ANCHO-1:0] dato_in,
    output logic [ANCHO-1:0] dato_out,
    output logic             lleno,
    output logic             vacio
);

    localparam int unsigned AP = $clog2(PROF);

    logic [AP:0]      wptr;
    logic [AP:0]      rptr;
    logic [ANCHO-1:0] mem [PROF];

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !lleno) begin
                wptr <= wptr + 1'b1;
            end
            if (pop && !vacio) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !lleno) begin
            mem[wptr[AP-1:0]] <= dato_in;
        end
    end

    assign dato_out = mem[rptr[AP-1:0]];
    assign vacio    = (wptr == rptr);
    // Same slot but different lap means the writer is a full buffer ahead.
    assign lleno    = (wptr[AP] != rptr[AP]) && (wptr[AP-1:0] == rptr[AP-1:0]);

endmodule

// File: rtl/planificador_cuenta.sv
// Sequencer feeding the ones-counting unit: buffers values, launches one count at a time,
// publishes each result and keeps a saturating total plus a completion counter.
module planificador_cuenta
    import planificador_cuenta_pkg::*;
#(
    parameter int unsigned PROF        = PROF_DEF,
    parameter int unsigned ANCHO_TOTAL = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ANCHO_VALOR-1:0]  dato_in,
    input  logic                    dato_valid,
    output logic                    dato_ready,
    output logic [ANCHO_VALOR-1:0]  Valor,
    output logic                    start,
    input  logic [ANCHO_CUENTA-1:0] Cuenta,
    input  logic                    fin,
    output logic [ANCHO_CUENTA-1:0] res,
    output logic                    res_valid,
    output logic [ANCHO_TOTAL-1:0]  total,
    output logic [3:0]              n_proc
);

    localparam int unsigned ANCHO_SUMA = ANCHO_TOTAL + 1;

    estado_t                estado;
    logic                   lleno;
    logic                   vacio;
    logic                   push;
    logic                   pop;
    logic [ANCHO_VALOR-1:0] dato_fifo;
    logic [ANCHO_SUMA-1:0]  suma;
    logic [ANCHO_TOTAL-1:0] total_sat;

    assign dato_ready = !lleno;
    assign push       = dato_valid && dato_ready;
    assign pop        = (estado == StIdle) && !vacio;

    fifo_valores #(
        .PROF  (PROF),
        .ANCHO (ANCHO_VALOR)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .dato_in  (dato_in),
        .dato_out (dato_fifo),
        .lleno    (lleno),
        .vacio    (vacio)
    );

    // One extra bit catches the carry so the clamp never wraps.
    assign suma      = ANCHO_SUMA'(total) + ANCHO_SUMA'(res);
    assign total_sat = suma[ANCHO_TOTAL] ? '1 : suma[ANCHO_TOTAL-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            estado    <= StIdle;
            Valor     <= '0;
            start     <= 1'b0;
            res       <= '0;
            res_valid <= 1'b0;
            total     <= '0;
            n_proc    <= '0;
        end else begin
            start     <= 1'b0;
            res_valid <= 1'b0;
            unique case (estado)
                StIdle: begin
                    if (!vacio) begin
                        Valor  <= dato_fifo;
                        start  <= 1'b1;
                        estado <= StLanza;
                    end
                end
                StLanza: begin
                    estado <= StEsperaBaja;
                end
                StEsperaBaja: begin
                    // fin may still be high from the previous count; wait for it to drop.
                    if (!fin) begin
                        estado <= StEsperaFin;
                    end
                end
                StEsperaFin: begin
                    if (fin) begin
                        res       <= Cuenta;
                        res_valid <= 1'b1;
                        estado    <= StEntrega;
                    end
                end
                StEntrega: begin
                    total  <= total_sat;
                    n_proc <= n_proc + 4'd1;
                    estado <= StIdle;
                end
                default: begin
                    estado <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/planificador_cuenta.md
# planificador_cuenta

Sequencer placed directly upstream of the ones-counting unit (3-bit value in, 4-bit count and `fin` out). Accepts 3-bit values over a valid/ready handshake and buffers them in a small FIFO. Launches one count at a time on the counting unit and captures each finished count. Publishes each result, plus a saturating running total of all counted ones.

## Interface
Parameters:
- `PROF`, 4: FIFO depth in entries; power of two, ≥2.
- `ANCHO_TOTAL`, 6: width of the running total.

Ports:
- `clk`  in  1  single system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `dato_in`  in  3  value to be counted.
- `dato_valid`  in  1  `dato_in` is valid this cycle.
- `dato_ready`  out  1  FIFO can accept; high when not full.
- `Valor`  out  3  value driven to the counting unit.
- `start`  out  1  one-cycle launch pulse to the counting unit.
- `Cuenta`  in  4  count returned by the counting unit.
- `fin`  in  1  counting unit done (level).
- `res`  out  4  last captured count.
- `res_valid`  out  1  one-cycle pulse; `res` is new.
- `total`  out  `ANCHO_TOTAL`  saturating sum of all captured counts.
- `n_proc`  out  4  number of completed counts, mod 16.

## Operation
- FIFO push occurs when `dato_valid && dato_ready`.
- FIFO pop occurs only on the IDLE→LANZA transition. The popped value is registered into `Valor` and held until the next launch.
- Simultaneous push and pop while the FIFO is full:
  - `dato_ready` is low, so the push is refused.
  - `dato_ready` is a function of the current occupancy only; a pop in the same cycle does not raise it.
- Push while the FIFO is empty: the value is not visible to the FSM until the next cycle; there is no bypass.

FSM states:
- IDLE: if the FIFO is non-empty, pop, load `Valor` and go to LANZA.
- LANZA: `start`=1 for exactly this cycle; go to ESPERA_BAJA.
- ESPERA_BAJA: wait for `fin`=0. This discards the stale `fin` left high by the previous count. Go to ESPERA_FIN.
- ESPERA_FIN: wait for `fin`=1. In that cycle register `res`←`Cuenta` and go to ENTREGA.
- ENTREGA: `res_valid`=1 for this cycle only.
  - `total` ← min(`total` + `res`, 2^`ANCHO_TOTAL` − 1).
  - `n_proc` ← `n_proc` + 1, wrapping 15→0.
  - Go to IDLE.

Arithmetic:
- `res` is zero-extended before the addition.
- The sum is computed at `ANCHO_TOTAL`+1 bits and clamped to the maximum.
- `Cuenta` > 3 is passed through unchanged; no range check.

Reset mid-operation:
- The FSM returns to IDLE and the FIFO is emptied.
- An in-flight count on the counting unit is abandoned and its `fin` is ignored.
- Any later launch re-synchronises through ESPERA_BAJA.

## Timing
Reset values: `dato_ready`=1 (from the first cycle after reset), `Valor`=0, `start`=0, `res`=0, `res_valid`=0, `total`=0, `n_proc`=0, FSM=IDLE, FIFO empty.

Cycle latencies:
- Push on edge k → `start` high in cycle k+2 at the earliest (IDLE sees non-empty at k+1, LANZA at k+2).
- `fin` seen high in ESPERA_FIN at cycle m → `res_valid` high in cycle m+1, together with the updated `res`.
- `total` and `n_proc` are updated at the end of cycle m+1 and visible from m+2.

Pipeline rules:
- Minimum gap between consecutive `start` pulses: LANZA, ESPERA_BAJA (≥1 cycle), ESPERA_FIN (≥1 cycle), ENTREGA, IDLE, i.e. ≥5 cycles plus the counting unit's latency.
- `Valor` is stable from LANZA until the next IDLE pop; the counting unit may sample it any time after `start`.

## Structure
- Shared package holds:
  - FSM state encoding: IDLE, LANZA, ESPERA_BAJA, ESPERA_FIN, ENTREGA.
  - `ANCHO_VALOR`=3 and `ANCHO_CUENTA`=4.
  - Default `PROF`.
- One sub-module: `fifo_valores`, a synchronous FIFO with width 3 and depth `PROF`.
  - Pointers `log2(PROF)`+1 bits; full/empty from pointer MSB comparison.
  - Outputs `lleno` and `vacio`; no output register.
- The top holds the FSM, the `Valor`/`res` registers, the total saturator and the `n_proc` counter.

## Test plan
- Single value: push 3'b101 with an idle FIFO.
  - `start` pulses once 2 cycles later with `Valor`=3'b101.
  - Model `fin` low 1 cycle then high after 3 cycles (`Cuenta`=2).
  - Then `res_valid` pulses once with `res`=2; `total`=2, `n_proc`=1.
- Full FIFO: push 5 values back-to-back while the counter model never raises `fin`.
  - `dato_ready` goes low after 5 accepted values: 1 popped, 4 buffered.
  - The 6th push is refused.
- Stale `fin`: hold `fin`=1 continuously during LANZA and for 2 cycles after.
  - No capture occurs until `fin` drops and rises again.
  - Captured `res` equals `Cuenta` at the rising occurrence.
- Saturation: feed 22 values of 3'b111 (`Cuenta`=3 each).
  - `total` reaches 63 at the 21st result and stays 63 after the 22nd.
  - `n_proc`=6 (22 mod 16).
- Reset mid-count: assert `reset` for 1 cycle while in ESPERA_FIN with 2 entries buffered.
  - All outputs return to reset values.
  - FIFO empty; no `start` is issued afterwards without a new push.
- Throughput/order: push values 1..4, with the counter model replying `Cuenta` = popcount.
  - `res` sequence is 1,1,2,1.
  - `start` pulses are ≥5 cycles apart and `Valor` order matches push order.
